counter_display_mux: RTL and testbench
======================================

Name: counter_display_mux

Overview:
- Parametrised N-digit up/down event counter with a time-multiplexed common-anode 7-segment driver.
- Successor to the fixed 4-digit timed counter display: digit count, count rate, scan rate and radix (BCD/hex) are configurable; adds direction, pause and a wrap pulse.
- Sits between the board clock and the display pins.

Parameters:
- N_DIGITS, 4, number of digits and width of on_off (1..8).
- TICK_CYCLES, 50000000, clk_in cycles per count step (≥2).
- REFRESH_CYCLES, 50000, clk_in cycles each digit stays lit (≥1).
- BCD, 1, 1 = decimal digits 0-9; 0 = hex digits 0-F.

Ports:
- clk_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- reset_count  in  1  synchronous count clear, active-high.
- enable  in  1  1 = counting; 0 = hold count and prescaler, scan continues.
- up_down  in  1  1 = increment, 0 = decrement.
- display  out  7  segments {g,f,e,d,c,b,a}, active-low.
- on_off  out  N_DIGITS  digit anodes, active-low, one-cold.
- wrap  out  1  one-cycle pulse on count wrap-around.

Behaviour:
- Reset (reset=0, async): count=0, prescaler=0, scan counter=0, digit_idx=0, display=7'b1111111, on_off=all 1, wrap=0.
- Prescaler: increments when enable=1; at TICK_CYCLES-1 it returns to 0 and raises internal tick for that cycle. Holds when enable=0.
- Count step on tick: in BCD mode each digit is 0-9 with ripple carry/borrow; in hex mode it is a plain 4*N_DIGITS-bit counter. Step direction is sampled from up_down in the tick cycle.
- Wrap: all-max→0 when counting up, or 0→all-max when counting down (9999/FFFF for N=4). wrap=1 in the same cycle the count register updates.
- reset_count=1 at an edge: count←0 and prescaler←0; no tick and no wrap that cycle. It has priority over a simultaneous tick. The scan is unaffected.
- Scan: the scan counter counts 0..REFRESH_CYCLES-1 always, including when enable=0. At terminal count, digit_idx←(digit_idx+1) mod N_DIGITS. Digit 0 is least significant.
- Outputs are registered with 1-cycle latency from count/digit_idx. At the edge after digit_idx=k (or the count) changes: on_off has only bit k=0, and display=seg(digit k).
- First edge after reset release: on_off bit0=0, display=seg(0)=7'b1000000.
- Segment codes: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- Reset asserted mid-scan or mid-count returns all state to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit displays 7'b1111111 when it and every more-significant digit are 0. Digit 0 is never blanked, so count 0 shows one "0". on_off timing is unchanged.
- Undefined: every digit shows its value, including leading zeros.

Test Plan:
Bench parameters: N_DIGITS=4, TICK_CYCLES=4, REFRESH_CYCLES=2, BCD=1 unless noted.
1. Hold reset=0 for 3 cycles, then release -> during reset display=7F, on_off=F, wrap=0; first edge after release on_off=4'b1110, display=7'b1000000.
2. enable=1, up_down=1 for 40 cycles -> count=0010 (BCD). The tick-to-tick interval is exactly 4 cycles. The digit 1 slot shows 7'b1111001.
3. Preload to 9999 via up-counting, then one more tick -> count=0000, wrap high exactly 1 cycle. With BCD=0, the same test at FFFF→0000 also pulses wrap.
4. Count=0000, up_down=0, one tick -> count=9999, wrap=1 for 1 cycle.
5. reset_count=1 on the same edge as a tick at count 0005 -> count=0000, wrap=0, prescaler restarts, so the next tick comes 4 cycles later.
6. enable=0 for 20 cycles at count 0042 -> count holds. on_off cycles 1110→1101→1011→0111 every 2 cycles. With LEADING_ZERO_BLANK_EN defined, digits 2-3 show 7F.

Source files
------------

// File: rtl/counter_display_mux.sv
// N-digit BCD/hex up/down event counter driving a multiplexed common-anode 7-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module counter_display_mux #(
   parameter int N_DIGITS       = 4,
   parameter int TICK_CYCLES    = 50000000,
   parameter int REFRESH_CYCLES = 50000,
   parameter int BCD            = 1
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                reset_count,
   input  logic                enable,
   input  logic                up_down,
   output logic [6:0]          display,
   output logic [N_DIGITS-1:0] on_off,
   output logic                wrap
);

   localparam int PRE_W  = $clog2(TICK_CYCLES);
   localparam int SCAN_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNT_W  = 4 * N_DIGITS;

   localparam logic [3:0]          DIGIT_MAX = (BCD != 0) ? 4'd9 : 4'd15;
   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
   localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'(REFRESH_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] ANODE_ONE = N_DIGITS'(1);

   logic [PRE_W-1:0]    pre_reg;
   logic [SCAN_W-1:0]   scan_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [CNT_W-1:0]    count_next;
   logic [N_DIGITS-1:0] at_edge;
   logic                tick;
   logic [3:0]          digit_cur;
   logic                blank_cur;

   // reset_count wins over a coincident tick, so the tick is masked here
   assign tick = enable && !reset_count && (pre_reg == PRE_LAST);

   // Each digit steps when every less-significant digit sits at its rollover value
   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         logic [3:0] d;
         logic       step_en;
         assign d           = count_reg[4*gi +: 4];
         assign at_edge[gi] = up_down ? (d == DIGIT_MAX) : (d == 4'd0);
         if (gi == 0) begin : g_lsd
            assign step_en = 1'b1;
         end else begin : g_upper
            assign step_en = &at_edge[gi-1:0];
         end
         assign count_next[4*gi +: 4] =
            !step_en    ? d :
            at_edge[gi] ? (up_down ? 4'd0 : DIGIT_MAX) :
            up_down     ? d + 4'd1 : d - 4'd1;
      end
   endgenerate

   assign digit_cur = count_reg[{idx_reg, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] upper_zero;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_blank
         assign upper_zero[gi] = ~|count_reg[CNT_W-1:4*gi];
      end
   endgenerate
   assign blank_cur = (idx_reg != '0) && upper_zero[idx_reg];
`else
   assign blank_cur = 1'b0;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         pre_reg   <= '0;
         scan_reg  <= '0;
         idx_reg   <= '0;
         count_reg <= '0;
         display   <= 7'b1111111;
         on_off    <= '1;
         wrap      <= 1'b0;
      end else begin
         // Scan runs regardless of enable / reset_count
         if (scan_reg == SCAN_LAST) begin
            scan_reg <= '0;
            idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
         end else begin
            scan_reg <= scan_reg + 1'b1;
         end

         on_off  <= ~(ANODE_ONE << idx_reg);
         display <= blank_cur ? 7'b1111111 : seg7(digit_cur);
         wrap    <= 1'b0;

         if (reset_count) begin
            count_reg <= '0;
            pre_reg   <= '0;
         end else if (enable) begin
            if (tick) begin
               pre_reg   <= '0;
               count_reg <= count_next;
               wrap      <= &at_edge;
            end else begin
               pre_reg <= pre_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_display_mux.sv
// Bench for counter_display_mux: BCD and hex instances against an integer-arithmetic reference model.
module tb_counter_display_mux;

   localparam int N = 4;
   localparam int T = 4;
   localparam int R = 2;
   localparam int MOD_D = 10000;
   localparam int MOD_H = 65536;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic reset_count = 1'b0;
   logic enable = 1'b0;
   logic up_down = 1'b1;

   logic [6:0]   display, display_h;
   logic [N-1:0] on_off, on_off_h;
   logic         wrap, wrap_h;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   counter_display_mux #(.N_DIGITS(N), .TICK_CYCLES(T), .REFRESH_CYCLES(R), .BCD(1)) dut (
      .clk_in(clk), .reset(rst_n), .reset_count(reset_count), .enable(enable),
      .up_down(up_down), .display(display), .on_off(on_off), .wrap(wrap));

   counter_display_mux #(.N_DIGITS(N), .TICK_CYCLES(T), .REFRESH_CYCLES(R), .BCD(0)) dut_hex (
      .clk_in(clk), .reset(rst_n), .reset_count(reset_count), .enable(enable),
      .up_down(up_down), .display(display_h), .on_off(on_off_h), .wrap(wrap_h));

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: counts held as plain integers modulo 10^N / 16^N
   int m_cnt = 0, m_cnt_h = 0, m_pre = 0, m_scan = 0, m_idx = 0;
   logic [6:0]   exp_display = 7'h7F, exp_display_h = 7'h7F;
   logic [N-1:0] exp_on_off = '1;
   logic         exp_wrap = 1'b0, exp_wrap_h = 1'b0;

   function automatic int pw(input int b, input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * b;
      return r;
   endfunction

   function automatic logic [6:0] shown(input int c, input int k, input int base);
      int upper = c / pw(base, k);
`ifdef LEADING_ZERO_BLANK_EN
      if (k != 0 && upper == 0) return 7'h7F;
`endif
      return seg_tab[upper % base];
   endfunction

   function automatic int stepped(input int c, input logic up, input int m);
      return up ? (c + 1) % m : (c + m - 1) % m;
   endfunction

   function automatic logic wraps(input int c, input logic up, input int m);
      return up ? (c == m - 1) : (c == 0);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0; m_cnt_h <= 0; m_pre <= 0; m_scan <= 0; m_idx <= 0;
         exp_display <= 7'h7F; exp_display_h <= 7'h7F; exp_on_off <= '1;
         exp_wrap <= 1'b0; exp_wrap_h <= 1'b0;
      end else begin
         exp_on_off    <= ~(4'b0001 << m_idx);
         exp_display   <= shown(m_cnt, m_idx, 10);
         exp_display_h <= shown(m_cnt_h, m_idx, 16);
         m_scan <= (m_scan == R - 1) ? 0 : m_scan + 1;
         if (m_scan == R - 1) m_idx <= (m_idx + 1) % N;
         exp_wrap <= 1'b0;
         exp_wrap_h <= 1'b0;
         if (reset_count) begin
            m_cnt <= 0; m_cnt_h <= 0; m_pre <= 0;
         end else if (enable) begin
            if (m_pre == T - 1) begin
               m_pre      <= 0;
               m_cnt      <= stepped(m_cnt, up_down, MOD_D);
               m_cnt_h    <= stepped(m_cnt_h, up_down, MOD_H);
               exp_wrap   <= wraps(m_cnt, up_down, MOD_D);
               exp_wrap_h <= wraps(m_cnt_h, up_down, MOD_H);
            end else begin
               m_pre <= m_pre + 1;
            end
         end
      end
   end

   logic [23:0] got_vec, exp_vec;
   assign got_vec = {display, on_off, wrap, display_h, on_off_h, wrap_h};
   assign exp_vec = {exp_display, exp_on_off, exp_wrap, exp_display_h, exp_on_off, exp_wrap_h};

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; up_down = 1'b1; reset_count = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (got_vec !== {7'h7F, 4'hF, 1'b0, 7'h7F, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", got_vec, {7'h7F, 4'hF, 1'b0, 7'h7F, 4'hF, 1'b0});
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({on_off, display, on_off_h, display_h} !== {4'b1110, 7'b1000000, 4'b1110, 7'b1000000}) begin
         failures++;
         $display("FAIL first_edge got on_off=%b display=%b exp on_off=1110 display=1000000", on_off, display);
      end
   endtask

   task automatic test_count_up();
      int i;
      enable = 1'b1; up_down = 1'b1;
      repeat (40) begin
         @(negedge clk);
         checks++;
         if (got_vec !== exp_vec) begin
            failures++;
            $display("FAIL count_up cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
         end
      end
      enable = 1'b0;
      @(negedge clk);
      for (i = 0; i < 16 && on_off !== 4'b1101; i++) @(negedge clk);
      checks++;
      if (on_off !== 4'b1101) begin
         failures++;
         $display("FAIL count_up_digit1_timeout got on_off=%b exp=1101", on_off);
      end else if (display !== 7'b1111001) begin
         failures++;
         $display("FAIL count_up_digit1 got=%b exp=1111001", display);
      end
   endtask

   task automatic test_wrap();
      int w, wh;
      logic seen;
      reset_count = 1'b1;
      @(negedge clk);
      reset_count = 1'b0;
      for (int phase = 0; phase < 2; phase++) begin
         up_down = (phase == 1);
         enable = 1'b1; w = 0; wh = 0; seen = 1'b0;
         for (int i = 0; i < 12; i++) begin
            if (i == 4) enable = 1'b0;
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
               failures++;
               $display("FAIL wrap_cycle phase=%0d cyc=%0d got=%h exp=%h", phase, cyc, got_vec, exp_vec);
            end
            if (wrap) w++;
            if (wrap_h) wh++;
            if (i >= 4 && phase == 0 && on_off === 4'b0111) begin
               seen = 1'b1;
               checks++;
               if ({display, display_h} !== {7'b0010000, 7'b0001110}) begin
                  failures++;
                  $display("FAIL wrap_down_msd got=%b/%b exp=0010000/0001110", display, display_h);
               end
            end
            if (i >= 4 && phase == 1 && on_off === 4'b1110) begin
               seen = 1'b1;
               checks++;
               if ({display, display_h} !== {7'b1000000, 7'b1000000}) begin
                  failures++;
                  $display("FAIL wrap_up_lsd got=%b/%b exp=1000000/1000000", display, display_h);
               end
            end
         end
         checks++;
         if (w != 1 || wh != 1 || !seen) begin
            failures++;
            $display("FAIL wrap_pulse_count phase=%0d got bcd=%0d hex=%0d seen=%b exp 1/1/1", phase, w, wh, seen);
         end
      end
   endtask

   task automatic test_reset_count_collision();
      int i;
      reset_count = 1'b1;
      @(negedge clk);
      reset_count = 1'b0; enable = 1'b1; up_down = 1'b1;
      repeat (20) @(negedge clk);
      for (i = 0; i < 8 && m_pre != T - 1; i++) @(negedge clk);
      checks++;
      if (m_cnt != 5) begin
         failures++;
         $display("FAIL rc_setup got model count=%0d exp=5", m_cnt);
      end
      reset_count = 1'b1;
      @(negedge clk);
      reset_count = 1'b0;
      checks++;
      if ({wrap, wrap_h} !== 2'b00) begin
         failures++;
         $display("FAIL rc_no_wrap got=%b%b exp=00", wrap, wrap_h);
      end
      repeat (14) begin
         @(negedge clk);
         checks++;
         if (got_vec !== exp_vec) begin
            failures++;
            $display("FAIL rc_after cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_hold();
      logic [6:0] want;
      reset_count = 1'b1;
      @(negedge clk);
      reset_count = 1'b0; enable = 1'b1; up_down = 1'b1;
      repeat (168) @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (got_vec !== exp_vec || $countones(~on_off) != 1) begin
            failures++;
            $display("FAIL hold_cycle cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
         end
         if (i > 0) begin
            case (on_off)
               4'b1110: want = 7'b0100100;
               4'b1101: want = 7'b0011001;
`ifdef LEADING_ZERO_BLANK_EN
               default: want = 7'b1111111;
`else
               default: want = 7'b1000000;
`endif
            endcase
            checks++;
            if (display !== want) begin
               failures++;
               $display("FAIL hold_digit on_off=%b got=%b exp=%b", on_off, display, want);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         enable      = ($urandom_range(0, 3) != 0);
         up_down     = $urandom_range(0, 1);
         reset_count = ($urandom_range(0, 49) == 0);
         if (i % 300 == 150) begin
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (got_vec !== {7'h7F, 4'hF, 1'b0, 7'h7F, 4'hF, 1'b0}) begin
               failures++;
               $display("FAIL async_reset got=%h exp=%h", got_vec, {7'h7F, 4'hF, 1'b0, 7'h7F, 4'hF, 1'b0});
            end
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
               failures++;
               $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
            end
         end
      end
      reset_count = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap();
      test_reset_count_collision();
      test_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
